// File: rtl/branch_seq.sv
// Instruction-cycle sequencer and branch resolver for picoMIPS: FETCH/EXEC/INC phases, zero flag,
// registered branch select/target. Define BRANCH_SEQ_HALT_DETECT_EN to stop on branch-to-self.
module branch_seq #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] pc_addr,
   input  logic [1:0]            br_type,
   input  logic [ADDR_WIDTH-1:0] br_target,
   input  logic                  alu_zero,
   input  logic                  flag_we,
   input  logic                  busy,
   output logic [1:0]            cycle,
   output logic                  branch,
   output logic [ADDR_WIDTH-1:0] branch_addr,
   output logic                  halted
);

   typedef enum logic [1:0] {
      StFetch = 2'b00,
      StExec  = 2'b01,
      StInc   = 2'b10,
      StHalt  = 2'b11
   } state_e;

   state_e                state_q, state_d;
   logic                  z_q, z_d;
   logic                  branch_q, branch_d;
   logic [ADDR_WIDTH-1:0] branch_addr_q, branch_addr_d;

   logic exec_exit;
   logic zeff;
   logic taken;
   logic halt_hit;

   assign exec_exit = (state_q == StExec) && !busy;
   // Same-instruction compare-and-branch must see the fresh flag, not the stored one.
   assign zeff      = flag_we ? alu_zero : z_q;

   always_comb begin
      taken = 1'b0;
      unique case (br_type)
         2'b00:   taken = 1'b0;
         2'b01:   taken = 1'b1;
         2'b10:   taken = zeff;
         2'b11:   taken = !zeff;
         default: taken = 1'b0;
      endcase
   end

`ifdef BRANCH_SEQ_HALT_DETECT_EN
   assign halt_hit = taken && (br_target == pc_addr);
`else
   logic unused_pc_addr;
   assign unused_pc_addr = ^pc_addr;
   assign halt_hit       = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      z_d           = z_q;
      branch_d      = 1'b0;
      branch_addr_d = branch_addr_q;
      unique case (state_q)
         StFetch: state_d = StExec;
         StExec: begin
            if (!busy) begin
               state_d = halt_hit ? StHalt : StInc;
               if (flag_we) begin
                  z_d = alu_zero;
               end
               if (taken) begin
                  branch_addr_d = br_target;
               end
               branch_d = taken && !halt_hit;
            end
         end
         StInc:   state_d = StFetch;
         StHalt:  state_d = StHalt;
         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StFetch;
         z_q           <= 1'b0;
         branch_q      <= 1'b0;
         branch_addr_q <= '0;
      end else begin
         state_q       <= state_d;
         z_q           <= z_d;
         branch_q      <= branch_d;
         branch_addr_q <= branch_addr_d;
      end
   end

   assign cycle       = state_q;
   assign branch      = branch_q;
   assign branch_addr = branch_addr_q;
   assign halted      = (state_q == StHalt);

   logic unused_exec_exit;
   assign unused_exec_exit = exec_exit;

endmodule
